wb_bus_arbiter: RTL and testbench
=================================

# wb_bus_arbiter

Arbitrates the shared Wishbone system bus between the К1801ВМ2 CPU wrapper and up to `NDMA` DMA masters, such as disk controllers.
- Drives the CPU's `cpu_gnt_i` input: 1 = CPU owns the bus, 0 = the CPU is disconnected and stalls waiting for ack.
- Drives one grant per DMA master.
- Ownership changes only at bus-cycle boundaries, with one dead cycle at every handover.
- DMA requests are served round-robin.
- The CPU gets a guaranteed slot by limiting DMA tenure and keeping a minimum CPU window.

## Interface
Parameters:
- `NDMA`, 2: number of DMA masters, 1..8.
- `HOLD_MAX`, 64: maximum clk_p cycles one DMA tenure lasts before forced release; 0 = unlimited.
- `CPU_SLOT`, 8: minimum cycles the CPU keeps the bus after regaining it; 0 = none.

Ports:
- `clk_p`  in  1  bus clock (100 MHz busclk).
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_cyc_i`  in  1  CPU Wishbone cycle active (local_cyc, including shadow cycles).
- `dma_req_i`  in  NDMA  per-master bus request; level, held for the whole tenure.
- `dma_cyc_i`  in  NDMA  per-master Wishbone cyc.
- `cpu_gnt_o`  out  1  grant to CPU, connects to `cpu_gnt_i`.
- `dma_gnt_o`  out  NDMA  one-hot-or-zero grant to DMA masters.
- `owner_o`  out  3  index of the current or last DMA owner.
- `dma_active_o`  out  1  a DMA master holds the bus.

## Operation
States: CPU, GAP_IN, DMA, GAP_OUT.

**Reset** (asynchronous, while `rst_n`=0):
- State CPU; `cpu_gnt_o`=1.
- `dma_gnt_o`=0, `dma_active_o`=0.
- `owner_o`=NDMA-1, so index 0 wins first.
- Counters cleared.

**CPU**
- Transition condition: `cpu_cyc_i`=0, the slot counter is 0, and some `dma_req_i` bit is 1.
- Select: the first requesting index after `owner_o`, scanning upward with wrap (round-robin). Latch it into `owner_o`.
- Go to GAP_IN and clear `cpu_gnt_o`.
- If `cpu_cyc_i`=1, stay in CPU; an in-progress CPU cycle is never cut.

**GAP_IN** (1 cycle)
- If `dma_req_i[owner]` is still 1: go to DMA, set `dma_gnt_o[owner]`, load the hold counter.
- Otherwise: return to CPU and set `cpu_gnt_o` without starting a slot window.

**DMA**
- Hold counter decrements each cycle while nonzero (when `HOLD_MAX`>0).
- Release when either:
  - `dma_req_i[owner]`=0, or
  - the hold counter is 0 and `dma_cyc_i[owner]`=0.
- On release: clear `dma_gnt_o` and go to GAP_OUT.
- Forced release never occurs while `dma_cyc_i[owner]`=1; it waits for the cycle boundary.
- Requests from other masters during DMA are ignored until the next CPU window.

**GAP_OUT** (1 cycle)
- Go to CPU, set `cpu_gnt_o`, load the slot counter with `CPU_SLOT`.

**Slot counter**
- Decrements in CPU state, saturating at 0.

**Arithmetic**
- Hold counter is `$clog2(HOLD_MAX+1)` bits; slot counter is `$clog2(CPU_SLOT+1)` bits.
- Round-robin search wraps from NDMA-1 to 0.
- Indices ≥ NDMA never appear.

## Timing
- All outputs are registered; none are combinational from inputs.
- `cpu_gnt_o` and `dma_gnt_o` are never 1 simultaneously; one cycle with both 0 at every handover.
- **Grant latency:** request sampled at edge N with CPU idle and slot 0 → `cpu_gnt_o`=0 after N, `dma_gnt_o` after N+1.
- **Return latency:** `dma_req_i` low at edge N → `dma_gnt_o`=0 after N, `cpu_gnt_o`=1 after N+1.
- **`dma_active_o`** = 1 exactly while `dma_gnt_o` is nonzero.
- **Simultaneous requests:** round-robin order decides; two back-to-back tenures are always separated by at least GAP_OUT plus `CPU_SLOT` CPU cycles.
- **Reset mid-tenure:** grants drop immediately (asynchronous); the CPU owns the bus on the first edge after `rst_n` rises.

## Test plan
- **Reset:** `rst_n`=0 during a DMA tenure → `cpu_gnt_o`=1 and `dma_gnt_o`=0 asynchronously; after release, a `dma_req_i`=01 request is granted to index 0.
- **Basic handover:** `dma_req_i`=01 with `cpu_cyc_i`=0 at edge N → `cpu_gnt_o`=0 after N, `dma_gnt_o`=01 after N+1; drop req at edge M → `dma_gnt_o`=00 after M, `cpu_gnt_o`=1 after M+1.
- **CPU cycle protection:** `cpu_cyc_i`=1 for 5 cycles with req pending → `cpu_gnt_o` stays 1 until `cpu_cyc_i` is sampled 0, then the handover proceeds.
- **Round-robin:** `dma_req_i`=11 held continuously, `HOLD_MAX`=4, `CPU_SLOT`=2 → grant order 01, 10, 01…, with at least 3 CPU-granted cycles between tenures.
- **Forced release:** `HOLD_MAX`=4 with `dma_cyc_i` high at count 0 → grant held until `dma_cyc_i`=0, then released next edge.
- **Abort in GAP_IN:** req drops during GAP_IN → `cpu_gnt_o` back to 1 next edge, no DMA grant issued, no slot delay.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Wishbone system-bus arbiter: CPU wrapper versus NDMA round-robin DMA masters.
// Ownership moves only between bus cycles, with one dead cycle at each handover.
// DMA tenure is bounded by a hold counter. The CPU keeps a minimum window after
// it regains the bus.
module wb_bus_arbiter #(
   parameter int NDMA     = 2,
   parameter int HOLD_MAX = 64,
   parameter int CPU_SLOT = 8
) (
   input  logic            clk_p,
   input  logic            rst_n,
   input  logic            cpu_cyc_i,
   input  logic [NDMA-1:0] dma_req_i,
   input  logic [NDMA-1:0] dma_cyc_i,
   output logic            cpu_gnt_o,
   output logic [NDMA-1:0] dma_gnt_o,
   output logic [2:0]      owner_o,
   output logic            dma_active_o
);

   // A parameter value of 0 still needs a 1-bit counter so the vectors stay legal.
   localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam int SW = (CPU_SLOT > 0) ? $clog2(CPU_SLOT + 1) : 1;

   localparam logic [1:0] ST_CPU     = 2'd0;
   localparam logic [1:0] ST_GAP_IN  = 2'd1;
   localparam logic [1:0] ST_DMA     = 2'd2;
   localparam logic [1:0] ST_GAP_OUT = 2'd3;

   logic [1:0]      state_q, state_d;
   logic            cpu_gnt_q, cpu_gnt_d;
   logic [NDMA-1:0] dma_gnt_q, dma_gnt_d;
   logic [2:0]      owner_q, owner_d;
   logic            active_q, active_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [SW-1:0]   slot_q, slot_d;

   logic [NDMA-1:0] owner_oh;
   logic            owner_req;
   logic            owner_cyc;
   logic            hold_expired;
   logic            hi_found;
   logic [2:0]      hi_idx;
   logic [2:0]      lo_idx;
   logic [2:0]      pick_idx;

   // One-hot decode of the latched owner, so the owner's request and cyc can be
   // selected without indexing a narrow vector with the 3-bit owner field.
   for (genvar gi = 0; gi < NDMA; gi++) begin : g_owner_oh
      assign owner_oh[gi] = (owner_q == 3'(gi));
   end

   assign owner_req    = |(dma_req_i & owner_oh);
   assign owner_cyc    = |(dma_cyc_i & owner_oh);
   assign hold_expired = (HOLD_MAX > 0) && (hold_q == '0);

   // Round-robin pick. The lowest requester above the last owner wins; otherwise
   // the search wraps to the lowest requester overall, which may be the owner.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NDMA - 1; i >= 0; i--) begin
         if (dma_req_i[i]) begin
            lo_idx = 3'(i);
            if (i > int'(owner_q)) begin
               hi_found = 1'b1;
               hi_idx   = 3'(i);
            end
         end
      end
      pick_idx = hi_found ? hi_idx : lo_idx;
   end

   // Next-state and next-output logic for the ownership FSM and both counters.
   always_comb begin
      state_d   = state_q;
      cpu_gnt_d = cpu_gnt_q;
      dma_gnt_d = dma_gnt_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      slot_d    = slot_q;
      case (state_q)
         ST_CPU: begin
            if (slot_q != '0) begin
               slot_d = slot_q - SW'(1);
            end
            // An in-progress CPU cycle is never cut, and the slot window must expire.
            if (!cpu_cyc_i && (slot_q == '0) && (|dma_req_i)) begin
               owner_d   = pick_idx;
               cpu_gnt_d = 1'b0;
               state_d   = ST_GAP_IN;
            end
         end
         ST_GAP_IN: begin
            if (owner_req) begin
               dma_gnt_d = owner_oh;
               hold_d    = HW'(HOLD_MAX);
               state_d   = ST_DMA;
            end else begin
               // The request was withdrawn: return to the CPU without a slot window.
               cpu_gnt_d = 1'b1;
               state_d   = ST_CPU;
            end
         end
         ST_DMA: begin
            if ((HOLD_MAX > 0) && (hold_q != '0)) begin
               hold_d = hold_q - HW'(1);
            end
            // A forced release waits for the owner's current bus cycle to end.
            if (!owner_req || (hold_expired && !owner_cyc)) begin
               dma_gnt_d = '0;
               state_d   = ST_GAP_OUT;
            end
         end
         default: begin
            cpu_gnt_d = 1'b1;
            slot_d    = SW'(CPU_SLOT);
            state_d   = ST_CPU;
         end
      endcase
      active_d = |dma_gnt_d;
   end

   // State and output registers; a reset drops DMA grants without waiting for a clock edge.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CPU;
         cpu_gnt_q <= 1'b1;
         dma_gnt_q <= '0;
         owner_q   <= 3'(NDMA - 1);
         active_q  <= 1'b0;
         hold_q    <= '0;
         slot_q    <= '0;
      end else begin
         state_q   <= state_d;
         cpu_gnt_q <= cpu_gnt_d;
         dma_gnt_q <= dma_gnt_d;
         owner_q   <= owner_d;
         active_q  <= active_d;
         hold_q    <= hold_d;
         slot_q    <= slot_d;
      end
   end

   assign cpu_gnt_o    = cpu_gnt_q;
   assign dma_gnt_o    = dma_gnt_q;
   assign owner_o      = owner_q;
   assign dma_active_o = active_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter (NDMA=2, HOLD_MAX=4, CPU_SLOT=2).
// Stimulus pushes the expected grant changes, each tagged with the clock edge
// after which it must appear. The monitor pops one entry on every observed
// grant change.
module tb_wb_bus_arbiter;

   localparam int NDMA = 2;

   logic            clk_p = 1'b0;
   logic            rst_n = 1'b0;
   logic            cpu_cyc_i = 1'b0;
   logic [NDMA-1:0] dma_req_i = '0;
   logic [NDMA-1:0] dma_cyc_i = '0;
   logic            cpu_gnt_o;
   logic [NDMA-1:0] dma_gnt_o;
   logic [2:0]      owner_o;
   logic            dma_active_o;

   wb_bus_arbiter #(.NDMA(NDMA), .HOLD_MAX(4), .CPU_SLOT(2)) dut (
      .clk_p        (clk_p),
      .rst_n        (rst_n),
      .cpu_cyc_i    (cpu_cyc_i),
      .dma_req_i    (dma_req_i),
      .dma_cyc_i    (dma_cyc_i),
      .cpu_gnt_o    (cpu_gnt_o),
      .dma_gnt_o    (dma_gnt_o),
      .owner_o      (owner_o),
      .dma_active_o (dma_active_o)
   );

   always #5 clk_p = ~clk_p;

   typedef struct {
      int         at_edge;
      logic       cpu;
      logic [1:0] dma;
      logic [2:0] owner;
      logic       act;
   } ev_t;

   ev_t  exp_q[$];
   int   edge_n = 0;
   int   checks = 0;
   int   failures = 0;
   logic [2:0] prev_obs = 3'b100;

   always @(posedge clk_p) edge_n <= edge_n + 1;

   task automatic push_ev(input int at, input logic c, input logic [1:0] d,
                          input logic [2:0] o, input logic a);
      ev_t ev;
      ev.at_edge = at; ev.cpu = c; ev.dma = d; ev.owner = o; ev.act = a;
      exp_q.push_back(ev);
   endtask

   task automatic check_now(input string name, input logic c, input logic [1:0] d,
                            input logic [2:0] o, input logic a);
      checks++;
      if (cpu_gnt_o !== c || dma_gnt_o !== d || owner_o !== o || dma_active_o !== a) begin
         failures++;
         $display("FAIL %s: got cpu=%b dma=%b owner=%0d act=%b, want cpu=%b dma=%b owner=%0d act=%b",
                  name, cpu_gnt_o, dma_gnt_o, owner_o, dma_active_o, c, d, o, a);
      end else begin
         $display("ok   %s: cpu=%b dma=%b owner=%0d act=%b", name, c, d, o, a);
      end
   endtask

   // Monitor: invariants every cycle, and a scoreboard pop on each grant change.
   always @(negedge clk_p) begin
      logic [2:0] obs;
      ev_t ev;
      checks++;
      if ((cpu_gnt_o && (|dma_gnt_o)) || (dma_active_o !== (|dma_gnt_o))) begin
         failures++;
         $display("FAIL invariant @edge %0d: cpu=%b dma=%b act=%b", edge_n, cpu_gnt_o, dma_gnt_o, dma_active_o);
      end
      obs = {cpu_gnt_o, dma_gnt_o};
      if (obs !== prev_obs) begin
         prev_obs = obs;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change @edge %0d: cpu=%b dma=%b owner=%0d", edge_n, cpu_gnt_o, dma_gnt_o, owner_o);
         end else begin
            ev = exp_q.pop_front();
            if (ev.at_edge != edge_n || cpu_gnt_o !== ev.cpu || dma_gnt_o !== ev.dma ||
                owner_o !== ev.owner || dma_active_o !== ev.act) begin
               failures++;
               $display("FAIL grant_change: got edge=%0d cpu=%b dma=%b owner=%0d act=%b, want edge=%0d cpu=%b dma=%b owner=%0d act=%b",
                        edge_n, cpu_gnt_o, dma_gnt_o, owner_o, dma_active_o,
                        ev.at_edge, ev.cpu, ev.dma, ev.owner, ev.act);
            end else begin
               $display("ok   edge %0d: cpu=%b dma=%b owner=%0d act=%b", edge_n, ev.cpu, ev.dma, ev.owner, ev.act);
            end
         end
      end
   end

   initial begin
      int e;
      int m;

      // Reset state
      repeat (3) @(negedge clk_p);
      check_now("reset_state", 1'b1, 2'b00, 3'd1, 1'b0);
      rst_n = 1'b1;

      // Basic handover and request-drop return
      repeat (2) @(negedge clk_p);
      dma_req_i = 2'b01;
      e = edge_n + 1;
      push_ev(e,     1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(e + 1, 1'b0, 2'b01, 3'd0, 1'b1);
      repeat (3) @(negedge clk_p);
      dma_req_i = 2'b00;
      m = edge_n + 1;
      push_ev(m,     1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(m + 1, 1'b1, 2'b00, 3'd0, 1'b0);

      // A CPU cycle in progress blocks the handover for 5 cycles
      repeat (5) @(negedge clk_p);
      cpu_cyc_i = 1'b1;
      dma_req_i = 2'b01;
      repeat (5) @(negedge clk_p);
      cpu_cyc_i = 1'b0;
      e = edge_n + 1;
      push_ev(e,     1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(e + 1, 1'b0, 2'b01, 3'd0, 1'b1);
      repeat (3) @(negedge clk_p);
      dma_req_i = 2'b00;
      m = edge_n + 1;
      push_ev(m,     1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(m + 1, 1'b1, 2'b00, 3'd0, 1'b0);

      // Forced release waits for dma_cyc to drop
      repeat (6) @(negedge clk_p);
      dma_req_i = 2'b10;
      dma_cyc_i = 2'b10;
      e = edge_n + 1;
      push_ev(e,     1'b0, 2'b00, 3'd1, 1'b0);
      push_ev(e + 1, 1'b0, 2'b10, 3'd1, 1'b1);
      repeat (8) @(negedge clk_p);
      dma_cyc_i = 2'b00;
      m = edge_n + 1;
      push_ev(m,     1'b0, 2'b00, 3'd1, 1'b0);
      push_ev(m + 1, 1'b1, 2'b00, 3'd1, 1'b0);
      @(negedge clk_p);
      dma_req_i = 2'b00;

      // Round-robin with both masters requesting; hold expiry and a CPU slot between tenures
      repeat (6) @(negedge clk_p);
      dma_req_i = 2'b11;
      e = edge_n + 1;
      push_ev(e,      1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(e + 1,  1'b0, 2'b01, 3'd0, 1'b1);
      push_ev(e + 6,  1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(e + 7,  1'b1, 2'b00, 3'd0, 1'b0);
      push_ev(e + 10, 1'b0, 2'b00, 3'd1, 1'b0);
      push_ev(e + 11, 1'b0, 2'b10, 3'd1, 1'b1);
      push_ev(e + 16, 1'b0, 2'b00, 3'd1, 1'b0);
      push_ev(e + 17, 1'b1, 2'b00, 3'd1, 1'b0);
      push_ev(e + 20, 1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(e + 21, 1'b0, 2'b01, 3'd0, 1'b1);
      push_ev(e + 23, 1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(e + 24, 1'b1, 2'b00, 3'd0, 1'b0);
      repeat (23) @(negedge clk_p);
      dma_req_i = 2'b00;

      // Request withdrawn during GAP_IN; a new request is taken with no slot delay
      repeat (6) @(negedge clk_p);
      dma_req_i = 2'b01;
      e = edge_n + 1;
      push_ev(e,     1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(e + 1, 1'b1, 2'b00, 3'd0, 1'b0);
      push_ev(e + 2, 1'b0, 2'b00, 3'd1, 1'b0);
      push_ev(e + 3, 1'b0, 2'b10, 3'd1, 1'b1);
      push_ev(e + 4, 1'b0, 2'b00, 3'd1, 1'b0);
      push_ev(e + 5, 1'b1, 2'b00, 3'd1, 1'b0);
      @(negedge clk_p);
      dma_req_i = 2'b00;
      @(negedge clk_p);
      dma_req_i = 2'b10;
      repeat (2) @(negedge clk_p);
      dma_req_i = 2'b00;

      // Reset in the middle of a tenure, then a fresh request to index 0
      repeat (6) @(negedge clk_p);
      dma_req_i = 2'b10;
      e = edge_n + 1;
      push_ev(e,     1'b0, 2'b00, 3'd1, 1'b0);
      push_ev(e + 1, 1'b0, 2'b10, 3'd1, 1'b1);
      push_ev(e + 3, 1'b1, 2'b00, 3'd1, 1'b0);
      repeat (3) @(negedge clk_p);
      #2;
      rst_n = 1'b0;
      #1;
      check_now("async_reset", 1'b1, 2'b00, 3'd1, 1'b0);
      dma_req_i = 2'b01;
      repeat (2) @(negedge clk_p);
      rst_n = 1'b1;
      e = edge_n + 1;
      push_ev(e,     1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(e + 1, 1'b0, 2'b01, 3'd0, 1'b1);
      push_ev(e + 2, 1'b0, 2'b00, 3'd0, 1'b0);
      push_ev(e + 3, 1'b1, 2'b00, 3'd0, 1'b0);
      repeat (2) @(negedge clk_p);
      dma_req_i = 2'b00;

      // Drain: every expected grant change must have been seen
      repeat (8) @(negedge clk_p);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d expected events still pending, want 0 (next at edge %0d)",
                  exp_q.size(), exp_q[0].at_edge);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
